flop_en_r: RTL and testbench

// - Parameterised D register with clock enable and synchronous reset.
// - Generic state-holding element for the multicycle datapath.
// - Holds architectural/intermediate values (e.g. PC, instruction register,

---
 rtl/flop_en_r.sv | 38 +++
 tb/tb_flop_en_r.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/flop_en_r.sv
// Parameterised D register with load enable and synchronous active-low reset.
// Holds datapath state that only updates in cycles where the controller asserts en.
module flop_en_r #(
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_width_check
        $error("flop_en_r: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Unknown reset/en falls to the default arm so simulation shows X instead of holding.
    always_comb begin
        q_d = q_q;
        case ({reset, en})
            2'b00, 2'b01: q_d = RESET_VALUE;
            2'b11:        q_d = d;
            2'b10:        q_d = q_q;
            default:      q_d = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_flop_en_r.sv
// Self-checking bench for flop_en_r: three instances (32-bit/zero reset, 1-bit and
// 64-bit with all-ones reset) driven in lockstep against a queued reference model.
module tb_flop_en_r;

    localparam logic [31:0] RV32 = 32'h0000_0000;
    localparam logic [0:0]  RV1  = 1'b1;
    localparam logic [63:0] RV64 = {64{1'b1}};

    typedef struct {
        string       tag;
        logic [31:0] q32;
        logic [0:0]  q1;
        logic [63:0] q64;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] d32;
    logic [0:0]  d1;
    logic [63:0] d64;
    logic [31:0] q32;
    logic [0:0]  q1;
    logic [63:0] q64;

    logic [31:0] model32;
    logic [0:0]  model1;
    logic [63:0] model64;

    expect_t     scoreboard[$];
    int          n_compared;
    int          n_mismatched;

    flop_en_r #(.WIDTH(32), .RESET_VALUE(RV32)) dut32 (
        .clk(clk), .reset(reset), .en(en), .d(d32), .q(q32)
    );

    flop_en_r #(.WIDTH(1), .RESET_VALUE(RV1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .d(d1), .q(q1)
    );

    flop_en_r #(.WIDTH(64), .RESET_VALUE(RV64)) dut64 (
        .clk(clk), .reset(reset), .en(en), .d(d64), .q(q64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model advances with the edge the stimulus will hit; result is queued.
    task automatic modelEdge(input string tag);
        expect_t e;
        if (!reset) begin
            model32 = RV32;
            model1  = RV1;
            model64 = RV64;
        end else if (en) begin
            model32 = d32;
            model1  = d1;
            model64 = d64;
        end
        e.tag = tag;
        e.q32 = model32;
        e.q1  = model1;
        e.q64 = model64;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        if (scoreboard.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = scoreboard.pop_front();
        n_compared++;
        assert (q32 === e.q32) else begin
            n_mismatched++;
            $error("[TB] FAIL %s q32 observed=%h expected=%h", e.tag, q32, e.q32);
        end
        n_compared++;
        assert (q1 === e.q1) else begin
            n_mismatched++;
            $error("[TB] FAIL %s q1 observed=%h expected=%h", e.tag, q1, e.q1);
        end
        n_compared++;
        assert (q64 === e.q64) else begin
            n_mismatched++;
            $error("[TB] FAIL %s q64 observed=%h expected=%h", e.tag, q64, e.q64);
        end
    endtask

    // Drive inputs just after an edge, model the next edge, then check after it.
    task automatic applyStimulus(input string tag, input logic rst_v, input logic en_v,
                                 input logic [31:0] d32_v, input logic [0:0] d1_v,
                                 input logic [63:0] d64_v);
        reset = rst_v;
        en    = en_v;
        d32   = d32_v;
        d1    = d1_v;
        d64   = d64_v;
        modelEdge(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset pulses low and back high entirely between edges with en low.
    task automatic applyGlitch(input string tag);
        reset = 1'b1;
        en    = 1'b0;
        d32   = 32'hFFFF_0000;
        d1    = 1'b0;
        d64   = 64'h0;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        modelEdge(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model32 = '0;
        model1  = '0;
        model64 = '0;
        reset = 1'b0;
        en    = 1'b0;
        d32   = '0;
        d1    = '0;
        d64   = '0;
        @(posedge clk);
        #1;

        applyStimulus("reset",        1'b0, 1'b0, 32'h1111_2222, 1'b0, 64'h1);
        applyStimulus("load1",        1'b1, 1'b1, 32'hABCD_1234, 1'b0, 64'hDEAD_BEEF_ABCD_1234);
        applyStimulus("load2",        1'b1, 1'b1, 32'h0200_500C, 1'b1, 64'h0123_4567_89AB_CDEF);
        applyStimulus("rst_over_en",  1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 64'h0);
        applyStimulus("hold_a",       1'b1, 1'b0, 32'h1234_5678, 1'b0, 64'h1234_5678_1234_5678);
        applyStimulus("hold_b",       1'b1, 1'b0, 32'h8765_4321, 1'b0, 64'h8765_4321_8765_4321);
        applyStimulus("hold_c",       1'b1, 1'b0, 32'h1234_5678, 1'b0, 64'h0);
        applyStimulus("load_pre_gl",  1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 64'h5555_AAAA_5555_AAAA);
        applyGlitch("glitch_hold");
        applyStimulus("reset_again",  1'b0, 1'b0, 32'h7777_7777, 1'b0, 64'h7);
        applyStimulus("release_a",    1'b1, 1'b0, 32'h5A5A_5A5A, 1'b0, 64'h0);
        applyStimulus("release_b",    1'b1, 1'b0, 32'h5A5A_5A5A, 1'b0, 64'h0);
        applyStimulus("release_load", 1'b1, 1'b1, 32'h5A5A_5A5A, 1'b0, 64'hA5A5_A5A5_0000_FFFF);
        applyStimulus("load_ones",    1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus("load_zero",    1'b1, 1'b1, 32'h0000_0000, 1'b0, 64'h0);
        applyStimulus("hold_zero",    1'b1, 1'b0, 32'h8000_0001, 1'b1, 64'h8000_0000_0000_0001);
        applyStimulus("rst_ones",     1'b0, 1'b0, 32'h8000_0001, 1'b0, 64'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          $urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
